// File: rtl/spike_mon_pkg.sv
// rtl/spike_mon_pkg.sv - shared widths, ISI state encoding and saturating add for the spike rate monitor
package spike_mon_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] SAT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    NONE,
    ONE,
    TWO
  } isi_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic [CNT_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, value} + {1'b0, inc};
    return sum[CNT_W] ? SAT_MAX : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/spike_edge_detect.sv
// rtl/spike_edge_detect.sv - tick-gated rising-edge detector on the neuron spike level
module spike_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic spike,
  input  logic clr,
  output logic spike_event
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else if (clr) begin
      prev <= 1'b0;
    end else if (tick) begin
      prev <= spike;
    end
  end

  // A tick coinciding with clr is discarded, so it must not produce an event.
  assign spike_event = tick && spike && !prev && !clr;

endmodule

// File: rtl/spike_rate_monitor.sv
// rtl/spike_rate_monitor.sv - windowed spike rate, last inter-spike interval and burst flag
module spike_rate_monitor
  import spike_mon_pkg::*;
#(
  parameter int WINDOW_TICKS = 16,
  parameter int BURST_ISI    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             spike,
  input  logic             clr,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic [CNT_W-1:0] isi,
  output logic             isi_valid,
  output logic             burst
);

  localparam logic [CNT_W-1:0] WIN_LAST  = 8'(WINDOW_TICKS - 1);
  localparam logic [CNT_W-1:0] BURST_LIM = 8'(BURST_ISI);

  logic             spike_event;
  isi_state_t       state, state_nxt;
  logic [CNT_W-1:0] win_cnt, win_cnt_nxt;
  logic [CNT_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] isi_cnt, isi_cnt_nxt;
  logic [CNT_W-1:0] rate_nxt, isi_nxt;
  logic             rate_valid_nxt, isi_valid_nxt, burst_nxt;
  logic [CNT_W-1:0] ev_inc;

  spike_edge_detect u_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .spike       (spike),
    .clr         (clr),
    .spike_event (spike_event)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NONE;
      win_cnt    <= '0;
      acc        <= '0;
      isi_cnt    <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
      isi        <= '0;
      isi_valid  <= 1'b0;
      burst      <= 1'b0;
    end else begin
      state      <= state_nxt;
      win_cnt    <= win_cnt_nxt;
      acc        <= acc_nxt;
      isi_cnt    <= isi_cnt_nxt;
      rate       <= rate_nxt;
      rate_valid <= rate_valid_nxt;
      isi        <= isi_nxt;
      isi_valid  <= isi_valid_nxt;
      burst      <= burst_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    win_cnt_nxt    = win_cnt;
    acc_nxt        = acc;
    isi_cnt_nxt    = isi_cnt;
    rate_nxt       = rate;
    isi_nxt        = isi;
    rate_valid_nxt = 1'b0;
    ev_inc         = {{(CNT_W-1){1'b0}}, spike_event};

    if (clr) begin
      state_nxt   = NONE;
      win_cnt_nxt = '0;
      acc_nxt     = '0;
      isi_cnt_nxt = '0;
      rate_nxt    = '0;
      isi_nxt     = '0;
    end else if (tick) begin
      if (win_cnt == WIN_LAST) begin
        rate_nxt       = sat_inc(acc, ev_inc);
        acc_nxt        = '0;
        win_cnt_nxt    = '0;
        rate_valid_nxt = 1'b1;
      end else begin
        acc_nxt     = sat_inc(acc, ev_inc);
        win_cnt_nxt = win_cnt + 8'd1;
      end

      case (state)
        NONE: begin
          if (spike_event) begin
            state_nxt   = ONE;
            isi_cnt_nxt = '0;
          end
        end
        ONE, TWO: begin
          if (spike_event) begin
            state_nxt   = TWO;
            isi_nxt     = sat_inc(isi_cnt, 8'd1);
            isi_cnt_nxt = '0;
          end else begin
            isi_cnt_nxt = sat_inc(isi_cnt, 8'd1);
          end
        end
        default: state_nxt = NONE;
      endcase
    end

    // Flags come from next-state values so they land on the same edge as the event.
    isi_valid_nxt = (state_nxt == TWO);
    burst_nxt     = (state_nxt == TWO) && (isi_nxt <= BURST_LIM);
  end

endmodule

// File: tb/tb_spike_rate_monitor.sv
// tb/tb_spike_rate_monitor.sv - randomized and directed checks of spike_rate_monitor against an event-timestamp model
module tb_spike_rate_monitor;

  localparam int WA = 16;
  localparam int WB = 255;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic spike = 1'b0;
  logic clr = 1'b0;

  logic [7:0] rate_a, isi_a, rate_b, isi_b;
  logic rate_valid_a, isi_valid_a, burst_a;
  logic rate_valid_b, isi_valid_b, burst_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spike_rate_monitor #(.WINDOW_TICKS(WA), .BURST_ISI(BURST)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .spike(spike), .clr(clr),
    .rate(rate_a), .rate_valid(rate_valid_a), .isi(isi_a),
    .isi_valid(isi_valid_a), .burst(burst_a)
  );

  spike_rate_monitor #(.WINDOW_TICKS(WB), .BURST_ISI(BURST)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .spike(spike), .clr(clr),
    .rate(rate_b), .rate_valid(rate_valid_b), .isi(isi_b),
    .isi_valid(isi_valid_b), .burst(burst_b)
  );

  // Model: count ticks since reset/clr, timestamp events, derive window and interval by arithmetic.
  typedef struct {
    int prev;
    int ticks;
    int acc;
    int rate;
    int rate_valid;
    int n_ev;
    int t_last;
    int isi;
  } model_t;

  function automatic model_t m_reset();
    model_t r;
    r.prev = 0; r.ticks = 0; r.acc = 0; r.rate = 0; r.rate_valid = 0;
    r.n_ev = 0; r.t_last = 0; r.isi = 0;
    return r;
  endfunction

  function automatic model_t m_step(model_t m, int w, int t, int s, int c);
    model_t r;
    int idx;
    int ev;
    r = m;
    r.rate_valid = 0;
    if (c != 0) return m_reset();
    if (t == 0) return r;
    ev = (s != 0 && r.prev == 0) ? 1 : 0;
    r.prev = s;
    idx = r.ticks;
    r.ticks = r.ticks + 1;
    if (ev != 0) begin
      r.acc = r.acc + 1;
      if (r.n_ev >= 1) r.isi = (idx - r.t_last > 255) ? 255 : idx - r.t_last;
      r.t_last = idx;
      if (r.n_ev < 2) r.n_ev = r.n_ev + 1;
    end
    if (idx % w == w - 1) begin
      r.rate = (r.acc > 255) ? 255 : r.acc;
      r.acc = 0;
      r.rate_valid = 1;
    end
    return r;
  endfunction

  model_t ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= m_reset();
      mb <= m_reset();
    end else begin
      ma <= m_step(ma, WA, int'(tick), int'(spike), int'(clr));
      mb <= m_step(mb, WB, int'(tick), int'(spike), int'(clr));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("a_rate", int'(rate_a), ma.rate);
    check("a_rate_valid", int'(rate_valid_a), ma.rate_valid);
    check("a_isi", int'(isi_a), ma.isi);
    check("a_isi_valid", int'(isi_valid_a), (ma.n_ev >= 2) ? 1 : 0);
    check("a_burst", int'(burst_a), (ma.n_ev >= 2 && ma.isi <= BURST) ? 1 : 0);
    check("b_rate", int'(rate_b), mb.rate);
    check("b_rate_valid", int'(rate_valid_b), mb.rate_valid);
    check("b_isi", int'(isi_b), mb.isi);
    check("b_isi_valid", int'(isi_valid_b), (mb.n_ev >= 2) ? 1 : 0);
    check("b_burst", int'(burst_b), (mb.n_ev >= 2 && mb.isi <= BURST) ? 1 : 0);
  end

  task automatic do_tick(input logic s);
    tick = 1'b1;
    spike = s;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 10; i++) do_tick(logic'($urandom_range(0, 1)));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rate", int'(rate_a), 0);
    check("rst_rate_valid", int'(rate_valid_a), 0);
    check("rst_isi", int'(isi_a), 0);
    check("rst_isi_valid", int'(isi_valid_a), 0);
    check("rst_burst", int'(burst_a), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    spike = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 15; i++) do_tick(1'b0);
    tick = 1'b1; spike = 1'b1;
    @(negedge clk);
    check("post_rst_window_valid", int'(rate_valid_a), 1);
    check("post_rst_window_rate", int'(rate_a), 1);
    tick = 1'b0; spike = 1'b0;
    @(negedge clk);

    // Alternating spikes, two windows of 8 events each
    do_clr();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 15; i++) do_tick(logic'(i % 2 == 0));
      tick = 1'b1; spike = 1'b0;
      @(negedge clk);
      check("alt_rate_valid", int'(rate_valid_a), 1);
      check("alt_rate", int'(rate_a), 8);
      tick = 1'b0;
      @(negedge clk);
      check("alt_rate_valid_drop", int'(rate_valid_a), 0);
    end

    // Held spike counts once
    do_clr();
    for (int i = 0; i < 15; i++) do_tick(logic'(i < 5));
    tick = 1'b1; spike = 1'b0;
    @(negedge clk);
    check("held_rate", int'(rate_a), 1);
    tick = 1'b0;
    @(negedge clk);

    // ISI and burst
    do_clr();
    for (int i = 0; i <= 20; i++) begin
      do_tick(logic'(i == 3 || i == 6 || i == 20));
      if (i == 6) begin
        check("isi_first", int'(isi_a), 3);
        check("isi_first_valid", int'(isi_valid_a), 1);
        check("isi_first_burst", int'(burst_a), 1);
      end
      if (i == 20) begin
        check("isi_second", int'(isi_a), 14);
        check("isi_second_burst", int'(burst_a), 0);
      end
    end

    // ISI saturation
    do_clr();
    do_tick(1'b1);
    for (int i = 0; i < 300; i++) do_tick(1'b0);
    do_tick(1'b1);
    check("isi_sat_a", int'(isi_a), 255);
    check("isi_sat_b", int'(isi_b), 255);

    // Long window: events on odd ticks of 255
    do_clr();
    for (int i = 0; i < 254; i++) do_tick(logic'(i % 2 == 1));
    tick = 1'b1; spike = 1'b0;
    @(negedge clk);
    check("long_rate_valid", int'(rate_valid_b), 1);
    check("long_rate", int'(rate_b), 127);
    tick = 1'b0;
    @(negedge clk);

    // clr wins over a simultaneous event on the terminal tick
    do_clr();
    for (int i = 0; i < 15; i++) do_tick(logic'(i == 2 || i == 9));
    tick = 1'b1; spike = 1'b1; clr = 1'b1;
    @(negedge clk);
    check("clr_rate_valid", int'(rate_valid_a), 0);
    check("clr_rate", int'(rate_a), 0);
    check("clr_isi_valid", int'(isi_valid_a), 0);
    check("clr_isi", int'(isi_a), 0);
    tick = 1'b0; clr = 1'b0;
    @(negedge clk);
    do_tick(1'b1);
    check("clr_one_only", int'(isi_valid_a), 0);
    do_tick(1'b0);
    do_tick(1'b1);
    check("clr_then_isi", int'(isi_a), 2);
    check("clr_then_burst", int'(burst_a), 1);
    for (int i = 3; i < 15; i++) do_tick(1'b0);
    tick = 1'b1; spike = 1'b0;
    @(negedge clk);
    check("clr_window_restart_valid", int'(rate_valid_a), 1);
    check("clr_window_restart_rate", int'(rate_a), 2);
    tick = 1'b0;
    @(negedge clk);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      tick = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) spike = ~spike;
      clr = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    tick = 1'b0; clr = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
